// File: rtl/conv_mac.sv
// conv_mac: K_SIZE-tap signed 8x8 MAC over a pixel stream with snapshot kernel/ReLU and a held ready/valid result
module conv_mac #(
  parameter int K_SIZE = 25,
  parameter int ACC_W  = 21
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iStart,
  input  logic                  iRelu,
  input  logic [8*K_SIZE-1:0]   iKernel,
  input  logic [7:0]            iX,
  input  logic                  iValid,
  input  logic                  iReady,
  output logic                  oReady,
  output logic                  oBusy,
  output logic                  oValid,
  output logic [ACC_W-1:0]      oSum
);
  localparam int IW = K_SIZE > 1 ? $clog2(K_SIZE) : 1;
  typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} stateT;
  stateT state;
  logic [IW-1:0] idx;
  logic signed [15:0] prod;
  logic prodValid;
  logic [ACC_W-1:0] acc, accNext;
  logic [8*K_SIZE-1:0] kernelSnap;
  logic reluSnap;
  logic signed [7:0] weight;
  logic accept, start;
  always_comb begin
    weight  = kernelSnap[8*idx +: 8];
    accept  = state == ACC && iValid;
    start   = iStart && (state == IDLE || (state == OUT && iReady));
    accNext = prodValid ? acc + {{(ACC_W-16){prod[15]}}, prod} : acc;
  end
  assign oReady = state == ACC;
  assign oBusy  = state != IDLE;
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= IDLE;
      idx        <= '0;
      prod       <= '0;
      prodValid  <= 1'b0;
      acc        <= '0;
      kernelSnap <= '0;
      reluSnap   <= 1'b0;
      oSum       <= '0;
      oValid     <= 1'b0;
    end else begin
      acc       <= accNext;
      prodValid <= accept;
      if (accept) begin
        prod <= $signed(iX) * weight;
        idx  <= idx + 1'b1;
      end
      if (start) begin
        state      <= ACC;
        idx        <= '0;
        acc        <= '0;
        prodValid  <= 1'b0;
        kernelSnap <= iKernel;
        reluSnap   <= iRelu;
        oValid     <= 1'b0;
        oSum       <= '0;
      end else if (accept && idx == IW'(K_SIZE-1)) begin
        state <= DRAIN;
      end else if (state == DRAIN) begin
        state  <= OUT;
        oValid <= 1'b1;
        oSum   <= reluSnap && accNext[ACC_W-1] ? '0 : accNext;
      end else if (state == OUT && iReady) begin
        state  <= IDLE;
        oValid <= 1'b0;
        oSum   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_conv_mac.sv
// tb_conv_mac: randomized and directed checks of conv_mac against a plain-arithmetic window model
module tb_conv_mac;
  localparam int K = 25;
  localparam int W = 21;
  typedef logic signed [7:0] pixArr [K];
  logic clk = 1'b0;
  logic rst, start, relu, valid, ready;
  logic [8*K-1:0] kernel;
  logic [7:0] x;
  logic oReady, oBusy, oValid;
  logic [W-1:0] oSum;
  int nAssert = 0;
  int nFail = 0;
  conv_mac #(.K_SIZE(K), .ACC_W(W)) dut (
    .iCLK(clk), .iRST(rst), .iStart(start), .iRelu(relu), .iKernel(kernel),
    .iX(x), .iValid(valid), .iReady(ready), .oReady(oReady), .oBusy(oBusy),
    .oValid(oValid), .oSum(oSum)
  );
  always #5 clk = ~clk;
  function automatic logic [8*K-1:0] fill(input int w);
    logic [8*K-1:0] k;
    for (int i = 0; i < K; i++) k[8*i +: 8] = 8'(w);
    return k;
  endfunction
  function automatic logic [8*K-1:0] rndKernel();
    logic [8*K-1:0] k;
    for (int i = 0; i < K; i++) k[8*i +: 8] = 8'($urandom);
    return k;
  endfunction
  function automatic pixArr seqPix();
    pixArr p;
    for (int i = 0; i < K; i++) p[i] = 8'(i + 1);
    return p;
  endfunction
  function automatic pixArr constPix(input int v);
    pixArr p;
    for (int i = 0; i < K; i++) p[i] = 8'(v);
    return p;
  endfunction
  function automatic pixArr rndPix();
    pixArr p;
    for (int i = 0; i < K; i++) p[i] = 8'($urandom);
    return p;
  endfunction
  function automatic int model(input logic [8*K-1:0] k, input pixArr px, input bit r);
    int s = 0;
    for (int i = 0; i < K; i++) s += int'($signed(k[8*i +: 8])) * int'(px[i]);
    return (r && s < 0) ? 0 : s;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic startWin(input logic [8*K-1:0] k, input logic r);
    kernel = k;
    relu = r;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic feed(input pixArr px, input int n, input int gapPct, input bit noise);
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gapPct) begin
        valid = 1'b0;
        if (noise) begin
          start = 1'($urandom);
          relu = 1'($urandom);
          kernel = rndKernel();
        end
        step();
      end
      x = px[i];
      valid = 1'b1;
      if (noise) begin
        start = 1'($urandom);
        kernel = rndKernel();
      end
      step();
      valid = 1'b0;
      start = 1'b0;
    end
  endtask
  task automatic drain(output logic v0, output logic v1, output logic [W-1:0] s);
    v0 = oValid;
    step();
    v1 = oValid;
    s = oSum;
  endtask
  task automatic releaseOut();
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    valid = 1'b1;
    ready = 1'b1;
    relu = 1'b0;
    x = 8'd5;
    kernel = fill(1);
    step();
    step();
    rst = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    ready = 1'b0;
    nAssert++; if (oReady !== 1'b0) begin nFail++; $display("FAIL reset_oReady: got %b expected 0", oReady); end
    nAssert++; if (oBusy !== 1'b0) begin nFail++; $display("FAIL reset_oBusy: got %b expected 0", oBusy); end
    nAssert++; if (oValid !== 1'b0) begin nFail++; $display("FAIL reset_oValid: got %b expected 0", oValid); end
    nAssert++; if (oSum !== '0) begin nFail++; $display("FAIL reset_oSum: got %0d expected 0", $signed(oSum)); end
  endtask
  task automatic test_ones();
    logic v0, v1;
    logic [W-1:0] s;
    startWin(fill(1), 1'b0);
    nAssert++; if ({oReady, oBusy, oValid} !== 3'b110) begin nFail++; $display("FAIL ones_start: got rdy/busy/vld %b expected 110", {oReady, oBusy, oValid}); end
    feed(seqPix(), K, 0, 1'b0);
    nAssert++; if ({oReady, oBusy} !== 2'b01) begin nFail++; $display("FAIL ones_drain: got rdy/busy %b expected 01", {oReady, oBusy}); end
    drain(v0, v1, s);
    nAssert++; if (v0 !== 1'b0) begin nFail++; $display("FAIL ones_early_valid: got %b expected 0", v0); end
    nAssert++; if (v1 !== 1'b1) begin nFail++; $display("FAIL ones_valid: got %b expected 1", v1); end
    nAssert++; if (s !== W'(325)) begin nFail++; $display("FAIL ones_sum: got %0d expected 325", $signed(s)); end
    releaseOut();
    nAssert++; if ({oBusy, oValid} !== 2'b00) begin nFail++; $display("FAIL ones_idle: got busy/vld %b expected 00", {oBusy, oValid}); end
  endtask
  task automatic test_extreme();
    logic v0, v1;
    logic [W-1:0] s;
    startWin(fill(-128), 1'b1);
    feed(constPix(-128), K, 0, 1'b0);
    drain(v0, v1, s);
    nAssert++; if (s !== W'(409600)) begin nFail++; $display("FAIL extreme_sum: got %0d expected 409600", $signed(s)); end
    nAssert++; if (s !== W'(model(fill(-128), constPix(-128), 1'b1))) begin nFail++; $display("FAIL extreme_model: got %0d expected 409600", $signed(s)); end
    releaseOut();
  endtask
  task automatic test_relu();
    logic v0, v1;
    logic [W-1:0] s;
    startWin(fill(1), 1'b0);
    feed(constPix(-1), K, 0, 1'b0);
    drain(v0, v1, s);
    nAssert++; if (s !== W'(-25)) begin nFail++; $display("FAIL relu_off_sum: got %0d expected -25", $signed(s)); end
    releaseOut();
    startWin(fill(1), 1'b1);
    feed(constPix(-1), K, 0, 1'b0);
    drain(v0, v1, s);
    nAssert++; if (s !== W'(0)) begin nFail++; $display("FAIL relu_on_sum: got %0d expected 0", $signed(s)); end
    releaseOut();
  endtask
  task automatic test_gaps();
    logic v0, v1;
    logic [W-1:0] s;
    startWin(fill(1), 1'b0);
    feed(seqPix(), K, 40, 1'b0);
    drain(v0, v1, s);
    nAssert++; if (v1 !== 1'b1 || s !== W'(325)) begin nFail++; $display("FAIL gaps_sum: got vld %b sum %0d expected vld 1 sum 325", v1, $signed(s)); end
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      nAssert++; if ({oBusy, oValid} !== 2'b11 || oSum !== W'(325)) begin nFail++; $display("FAIL gaps_hold%0d: got busy/vld %b sum %0d expected 11 sum 325", c, {oBusy, oValid}, $signed(oSum)); end
    end
    start = 1'b0;
    releaseOut();
    nAssert++; if ({oBusy, oValid, oReady} !== 3'b000) begin nFail++; $display("FAIL gaps_idle: got busy/vld/rdy %b expected 000", {oBusy, oValid, oReady}); end
  endtask
  task automatic test_reset_mid();
    logic v0, v1;
    logic [W-1:0] s;
    startWin(fill(1), 1'b0);
    feed(seqPix(), 10, 0, 1'b0);
    rst = 1'b1;
    valid = 1'b1;
    step();
    rst = 1'b0;
    valid = 1'b0;
    nAssert++; if ({oReady, oBusy, oValid} !== 3'b000 || oSum !== '0) begin nFail++; $display("FAIL midreset_outputs: got rdy/busy/vld %b sum %0d expected 000 sum 0", {oReady, oBusy, oValid}, $signed(oSum)); end
    startWin(fill(1), 1'b0);
    feed(seqPix(), K, 0, 1'b0);
    drain(v0, v1, s);
    nAssert++; if (s !== W'(325)) begin nFail++; $display("FAIL midreset_sum: got %0d expected 325", $signed(s)); end
    releaseOut();
  endtask
  task automatic test_back_to_back();
    logic v0, v1;
    logic [W-1:0] s;
    logic [8*K-1:0] k2;
    pixArr p2;
    startWin(fill(1), 1'b0);
    kernel = fill(2);
    relu = 1'b1;
    feed(seqPix(), K, 0, 1'b0);
    drain(v0, v1, s);
    nAssert++; if (s !== W'(325)) begin nFail++; $display("FAIL snapshot_sum: got %0d expected 325", $signed(s)); end
    k2 = rndKernel();
    p2 = rndPix();
    kernel = k2;
    relu = 1'b1;
    start = 1'b1;
    ready = 1'b1;
    step();
    start = 1'b0;
    ready = 1'b0;
    nAssert++; if ({oReady, oBusy, oValid} !== 3'b110) begin nFail++; $display("FAIL b2b_restart: got rdy/busy/vld %b expected 110", {oReady, oBusy, oValid}); end
    feed(p2, K, 0, 1'b0);
    drain(v0, v1, s);
    nAssert++; if (s !== W'(model(k2, p2, 1'b1))) begin nFail++; $display("FAIL b2b_sum: got %0d expected %0d", $signed(s), model(k2, p2, 1'b1)); end
    releaseOut();
  endtask
  task automatic test_random();
    logic v0, v1;
    logic [W-1:0] s;
    logic [8*K-1:0] k;
    pixArr p;
    logic r;
    for (int n = 0; n < 8; n++) begin
      valid = 1'b1;
      x = 8'($urandom);
      step();
      valid = 1'b0;
      nAssert++; if (oBusy !== 1'b0) begin nFail++; $display("FAIL rnd%0d_idle_valid: got busy %b expected 0", n, oBusy); end
      k = rndKernel();
      p = rndPix();
      r = 1'($urandom);
      startWin(k, r);
      feed(p, K, 30, 1'b1);
      drain(v0, v1, s);
      nAssert++; if (v0 !== 1'b0 || v1 !== 1'b1) begin nFail++; $display("FAIL rnd%0d_latency: got %b%b expected 01", n, v0, v1); end
      nAssert++; if (s !== W'(model(k, p, r))) begin nFail++; $display("FAIL rnd%0d_sum: got %0d expected %0d", n, $signed(s), model(k, p, r)); end
      releaseOut();
    end
  endtask
  initial begin
    test_reset();
    test_ones();
    test_extreme();
    test_relu();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
